// File: rtl/serial_pattern_gen_if.sv
// ============================================================================
//  Module   : serial_pattern_gen_if
//  Brief    : Control/data bundle between a pattern source and the serial
//             pattern generator (master = generator side).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_pattern_gen_if #(
    parameter int PAT_W = 8
) ();
    logic             Start;
    logic [PAT_W-1:0] Pattern;
    logic [3:0]       Length;
    logic [3:0]       Repeat;
    logic             w;
    logic             w_valid;
    logic             Busy;
    logic             Done;
    logic [3:0]       CurState;

    // Generator view: takes the burst request, drives the serial stream.
    modport master (
        input  Start, Pattern, Length, Repeat,
        output w, w_valid, Busy, Done, CurState
    );

    // Requester view: issues the burst request, observes the stream.
    modport slave (
        output Start, Pattern, Length, Repeat,
        input  w, w_valid, Busy, Done, CurState
    );
endinterface

`default_nettype wire

// File: rtl/serial_pattern_gen.sv
// ============================================================================
//  Module   : serial_pattern_gen
//  Brief    : Loads a pattern word and shifts it out MSB-first on w, one bit
//             per TICK_DIV clocks, repeating with zero-filled gaps, then
//             pulses Done. Exposes the state code for a HEX display.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pattern_gen #(
    parameter int PAT_W    = 8,
    parameter int TICK_DIV = 1,
    parameter int GAP_BITS = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    serial_pattern_gen_if.master bus
);

    localparam logic [3:0] ST_IDLE  = 4'h0;
    localparam logic [3:0] ST_LOAD  = 4'h1;
    localparam logic [3:0] ST_SHIFT = 4'h2;
    localparam logic [3:0] ST_GAP   = 4'h3;
    localparam logic [3:0] ST_DONE  = 4'h4;

    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_CYC = GAP_BITS * TICK_DIV;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // GAP is unreachable when GAP_CYC is 0; the clamp only keeps the constant legal.
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [3:0]    PAT_W4    = 4'(PAT_W);

    logic [3:0]       state_q, state_d;
    logic [PAT_W-1:0] win_q,   win_d;    // live shift window, MSB is on w
    logic [PAT_W-1:0] copy_q,  copy_d;   // aligned copy used to reload repeats
    logic [3:0]       len_q,   len_d;    // effective burst length
    logic [3:0]       bit_q,   bit_d;    // bits left in current burst
    logic [3:0]       rep_q,   rep_d;    // repetitions still to send
    logic [TW-1:0]    tick_q,  tick_d;
    logic [GW-1:0]    gap_q,   gap_d;

    logic [3:0]       w_eff_len;
    logic [PAT_W-1:0] w_aligned;

    // Effective length and left-aligned pattern so bit Length-1 leaves first.
    always_comb begin
        w_eff_len = bus.Length;
        if ((bus.Length == 4'd0) || (bus.Length > PAT_W4)) begin
            w_eff_len = PAT_W4;
        end
        w_aligned = bus.Pattern << (PAT_W4 - w_eff_len);
    end

    // State register and datapath flops; reset aborts any burst immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            copy_q  <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            copy_q  <= copy_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state and counter updates for the burst sequencer.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        copy_d  = copy_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                win_d   = w_aligned;
                copy_d  = w_aligned;
                len_d   = w_eff_len;
                bit_d   = w_eff_len;
                rep_d   = bus.Repeat;
                tick_d  = '0;
                gap_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    win_d  = win_q << 1;
                    bit_d  = bit_q - 4'd1;
                    if (bit_q == 4'd1) begin
                        if (rep_q == 4'd0) begin
                            state_d = ST_DONE;
                        end else if (GAP_BITS > 0) begin
                            gap_d   = '0;
                            state_d = ST_GAP;
                        end else begin
                            // Back-to-back repeat: reload without leaving SHIFT.
                            win_d = copy_q;
                            bit_d = len_q;
                            rep_d = rep_q - 4'd1;
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    tick_d  = '0;
                    rep_d   = rep_q - 4'd1;
                    win_d   = copy_q;
                    bit_d   = len_q;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state; no input-to-output path.
    always_comb begin
        bus.CurState = state_q;
        bus.Busy     = (state_q != ST_IDLE);
        bus.w_valid  = (state_q == ST_SHIFT) || (state_q == ST_GAP);
        bus.w        = (state_q == ST_SHIFT) && win_q[PAT_W-1];
        bus.Done     = (state_q == ST_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
// ============================================================================
//  Module   : tb_serial_pattern_gen
//  Brief    : Self-checking bench for serial_pattern_gen; two instances with
//             different tick/gap settings share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_pattern_gen;

    localparam int PAT_W = 8;
    localparam int TA = 1, GA = 2;   // instance a: TICK_DIV, GAP_BITS
    localparam int TB = 3, GB = 1;   // instance b: TICK_DIV, GAP_BITS

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] pat    = '0;
    logic [3:0] len    = '0;
    logic [3:0] rep    = '0;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    serial_pattern_gen_if #(.PAT_W(PAT_W)) bus_a ();
    serial_pattern_gen_if #(.PAT_W(PAT_W)) bus_b ();

    assign bus_a.Start = start;  assign bus_b.Start = start;
    assign bus_a.Pattern = pat;  assign bus_b.Pattern = pat;
    assign bus_a.Length = len;   assign bus_b.Length = len;
    assign bus_a.Repeat = rep;   assign bus_b.Repeat = rep;

    serial_pattern_gen #(.PAT_W(PAT_W), .TICK_DIV(TA), .GAP_BITS(GA)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .bus(bus_a));
    serial_pattern_gen #(.PAT_W(PAT_W), .TICK_DIV(TB), .GAP_BITS(GB)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .bus(bus_b));

    // Observation word: {CurState, w, w_valid, Busy, Done}
    logic [7:0] obs_a, obs_b;
    assign obs_a = {bus_a.CurState, bus_a.w, bus_a.w_valid, bus_a.Busy, bus_a.Done};
    assign obs_b = {bus_b.CurState, bus_b.w, bus_b.w_valid, bus_b.Busy, bus_b.Done};

    function automatic int eff_of(input int l);
        return (l == 0 || l > PAT_W) ? PAT_W : l;
    endfunction

    // Busy cycles: LOAD + shifted bits + gaps + DONE.
    function automatic int busy_of(input int l, input int r, input int tick, input int gap);
        return 2 + (r + 1) * eff_of(l) * tick + r * gap * tick;
    endfunction

    // Expected observation for cycle cyc after Start is sampled (cycle 0 = LOAD).
    function automatic logic [7:0] model(input logic [7:0] p, input int l, input int r,
                                         input int tick, input int gap, input int cyc);
        int eff, burst, period, total, c, pos;
        eff    = eff_of(l);
        burst  = eff * tick;
        period = burst + gap * tick;
        total  = (r + 1) * burst + r * gap * tick;
        if (cyc == 0) return {4'h1, 4'b0010};
        c = cyc - 1;
        if (c < total) begin
            pos = c % period;
            if (pos < burst) return {4'h2, p[eff - 1 - pos / tick], 3'b110};
            return {4'h3, 4'b0110};
        end
        if (c == total) return {4'h4, 4'b0011};
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp, input int cyc);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One burst on both instances; optionally disturb inputs and re-pulse Start mid-SHIFT.
    task automatic run_burst(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                             input bit disturb);
        int na, nb, n;
        @(negedge Clock);
        pat = p; len = l; rep = r; start = 1'b1;
        na = busy_of(int'(l), int'(r), TA, GA);
        nb = busy_of(int'(l), int'(r), TB, GB);
        n  = ((na > nb) ? na : nb) + 2;
        @(posedge Clock);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            check("inst_a", obs_a, model(p, int'(l), int'(r), TA, GA, i), i);
            check("inst_b", obs_b, model(p, int'(l), int'(r), TB, GB, i), i);
            if (i == 0) start = 1'b0;
            if (i == 1) start = disturb;
            if (i == 2) start = 1'b0;
            if (disturb && i >= 1) begin
                pat = 8'($urandom);
                len = 4'($urandom);
                rep = 4'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_a", obs_a, 8'h00, -1);
        check("reset_b", obs_b, 8'h00, -1);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;

        // Directed cases
        run_burst(8'h0D, 4'd4, 4'd0, 1'b0);
        run_burst(8'h0D, 4'd4, 4'd1, 1'b0);
        run_burst(8'hA5, 4'd0, 4'd0, 1'b0);
        run_burst(8'hA5, 4'd9, 4'd0, 1'b0);
        run_burst(8'h03, 4'd2, 4'd0, 1'b0);
        run_burst(8'hB6, 4'd1, 4'd2, 1'b0);
        run_burst(8'h5A, 4'd8, 4'd1, 1'b1);

        // Reset mid-SHIFT: everything drops at once, no Done afterwards
        @(negedge Clock);
        pat = 8'hFF; len = 4'd8; rep = 4'd1; start = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start = 1'b0;
        repeat (3) @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("async_rst_a", obs_a, 8'h00, -1);
        check("async_rst_b", obs_b, 8'h00, -1);
        repeat (2) begin
            @(negedge Clock);
            check("held_rst_a", obs_a, 8'h00, -1);
            check("held_rst_b", obs_b, 8'h00, -1);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_rst_a", obs_a, 8'h00, -1);
        check("post_rst_b", obs_b, 8'h00, -1);

        // Fresh bursts after reset, then randomized ones
        run_burst(8'h0D, 4'd4, 4'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            run_burst(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                      1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial bit-stream generator. It is the transmit side feeding the serial `w` input of the team's Moore sequence-detector FSMs.
- Loads a pattern word, shifts it out MSB-first one bit per tick, optionally repeats it with zero-filled gaps, then pulses Done.
- Exposes its state code so the existing HEX_decoder can display it, mirroring the detector's CurState output.

Parameters:
- PAT_W, 8, width of Pattern; maximum bits per burst (2..15).
- TICK_DIV, 1, clock cycles each bit is held on w (1 = one bit per clock); internal divider counter.
- GAP_BITS, 2, number of forced-0 bit periods inserted between repetitions (0 = back-to-back).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  level; sampled only in IDLE; launches a burst.
- Pattern  in  PAT_W  bits to send; captured in LOAD.
- Length  in  4  number of bits sent, taken from Pattern[Length-1:0]; 0 or >PAT_W means PAT_W.
- Repeat  in  4  extra repetitions; total bursts = Repeat+1.
- w  out  1  serial data bit to the detector.
- w_valid  out  1  high while in SHIFT or GAP.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  single-cycle pulse at end of sequence.
- CurState  out  4  current state code, for HEX display.

Behaviour:
- State codes: IDLE=4'h0, LOAD=4'h1, SHIFT=4'h2, GAP=4'h3, DONE=4'h4. Any other code goes to IDLE on the next edge.
- Reset (Resetn=0, async): state=IDLE; w=0, w_valid=0, Busy=0, Done=0; all counters and shift register cleared. Reset mid-burst aborts immediately with no Done.
- IDLE: if Start=1 at an edge, go to LOAD; otherwise stay.
- LOAD (exactly 1 cycle):
  - Capture Pattern into the shift register, left-aligned so bit Length-1 is first.
  - Capture effective length into bit counter; capture Repeat into rep counter.
  - Clear tick counter, then go to SHIFT.
- SHIFT:
  - w = current MSB of the window.
  - Tick counter counts 0..TICK_DIV-1; at TICK_DIV-1, advance to next bit and decrement bit counter.
  - After the last bit's final tick:
    - rep counter ≠ 0 → GAP if GAP_BITS>0, else reload the window from the captured copy and stay in SHIFT.
    - rep counter = 0 → DONE.
- GAP:
  - w=0 for GAP_BITS*TICK_DIV cycles.
  - Then decrement rep counter, reload the bit window from the captured copy (not the live Pattern input), and go to SHIFT.
- DONE (1 cycle): Done=1, w=0, w_valid=0; then IDLE. Done is registered, high only in DONE.
- Timing:
  - First data bit appears on w 2 edges after Start is sampled.
  - Total Busy cycles = 2 + (Repeat+1)*Len*TICK_DIV + Repeat*GAP_BITS*TICK_DIV.
- w is 0 in IDLE, LOAD, GAP and DONE.
- Input changes while Busy: Start, Pattern, Length and Repeat are ignored. Start held high through DONE relaunches at the first IDLE edge, so IDLE lasts 1 cycle minimum.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Test Plan:
- Pattern=8'h0D, Length=4, Repeat=0, TICK_DIV=1 → w=1,1,0,1 on cycles 2..5 after Start; Done pulses at cycle 6; Busy high for exactly 6 cycles.
- Same stimulus, Repeat=1, GAP_BITS=2 → w = 1101 00 1101; w_valid high for 10 cycles; a single Done pulse; the detector fed by w asserts z at the expected positions.
- Length=0, Pattern=8'hA5 → 8 bits 1,0,1,0,0,1,0,1 are sent.
- Length=9 with PAT_W=8 → same result: 8 bits 1,0,1,0,0,1,0,1.
- TICK_DIV=3, Pattern=8'h03, Length=2 → each bit held for 3 cycles; w=1 for 6 consecutive cycles.
- Change Pattern and pulse Start mid-SHIFT → stream unchanged; no relaunch until after Done.
- Drop Resetn during SHIFT → w=0, Busy=0, CurState=0 asynchronously, with no Done pulse.
- After Resetn is released, Start → a fresh burst proceeds normally.
